jet_readout_l1: RTL
===================

// Module: jet_readout_L1
// PURPOSE
//  Reader for the jet-merger output memory. On a start pulse it latches the
//  merger's cluster count, walks read addresses 0..nclust-1 and absorbs the
//  fixed RAM read latency. It streams each jet word downstream on a
//  valid/ready interface, flagging the last jet and pulsing done at the end.
//  Sits between the eta-merge stage and the L1 jet sorter/serializer.
// PARAMETERS
//  JET_W    23  jet word width {ntrx[4:0], xcnt[3:0], eta[4:0], et[8:0]}
//  ADDR_W   5   memory address / count width
//  RD_LAT   2   cycles from jet_addr driven to matching jet_in sampled
//  FIFO_D   4   output FIFO depth; must be >= RD_LAT+1
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high reset
//  start      in   1       1-cycle pulse: merger finished, begin readout
//  nclust     in   ADDR_W  number of stored jets (0..31)
//  jet_addr   out  ADDR_W  read address to merger memory
//  jet_in     in   JET_W   read data from merger memory
//  out_jet    out  JET_W   jet word to downstream
//  out_idx    out  ADDR_W  memory index of out_jet
//  out_valid  out  1       out_jet/out_idx/out_last valid
//  out_ready  in   1       downstream accepts when valid&&ready
//  out_last   out  1       current beat is jet nclust-1
//  busy       out  1       readout in progress (start ignored)
//  done       out  1       1-cycle pulse: all jets accepted downstream
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-high. Reset values:
//    jet_addr=all-ones, out_jet=0, out_idx=0, out_valid=0, out_last=0,
//    busy=0, done=0, FIFO empty, in-flight pipe cleared, FSM=IDLE.
//  - FSM IDLE -> (start) latch N=nclust, busy=1 -> READ if N!=0 else DONE.
//  - READ: issue address a (0,1,..) on any cycle where
//    fifo_count + inflight < FIFO_D; inflight = issued reads not yet
//    written. Issue is a 1-bit pipe RD_LAT deep carrying the index.
//    After issuing N-1 -> DRAIN.
//  - Between issues, and in IDLE/DRAIN/DONE, jet_addr=all-ones.
//  - DRAIN: wait until inflight==0, FIFO empty and last beat accepted
//    -> DONE.
//  - DONE: done=1 for exactly one cycle, busy=0 next cycle -> IDLE.
//  - Read data: jet_in at cycle c+RD_LAT belongs to the address issued
//    at cycle c. It is written into the FIFO with its index on that edge.
//    The FIFO is show-ahead with registered outputs, so
//    issue->out_valid = RD_LAT+1 cycles when the FIFO is empty.
//  - Handshake: a beat is popped on out_valid&&out_ready. While
//    out_valid=1 and out_ready=0, out_jet/out_idx/out_last hold stable.
//    Simultaneous push and pop are allowed and count stays the same.
//  - Credit check guarantees no FIFO overflow. A push into a full FIFO
//    is a design error and is flagged by an assertion.
//  - out_last = (out_idx == N-1). Indices leave strictly in order 0..N-1,
//    with no drops or duplicates.
//  - start while busy=1 is ignored; N does not change mid-readout.
//    nclust changes after latch are ignored.
//  - Counters are ADDR_W wide. N=31 is the maximum, and the address
//    counter never wraps past N-1.
//  - Reset mid-readout aborts immediately. Any jet_in returning after
//    reset is discarded because the pipe is cleared, and no done pulse
//    is generated.
//  - Jet words pass through bit-exact; no field is modified.
// TESTING
//  1 start, nclust=3, ready=1, RD_LAT=2 -> jet_addr 0,1,2 at T+1..T+3;
//    out_valid T+4..T+6, out_idx 0,1,2, out_last only at T+6, done T+7.
//  2 start, nclust=0 -> no jet_addr!=31, no out_valid; done at T+1,
//    busy high only cycle T+1.
//  3 nclust=8, out_ready=0 -> exactly 4 addresses issued then stall.
//    Raise ready: 8 beats in order, each data = memory model[idx].
//  4 nclust=31, out_ready random 50% -> 31 beats idx 0..30, last on 30,
//    one done, no overflow assertion.
//  5 nclust=10, reset after 5 beats -> all outputs return to reset values
//    next cycle; stale jet_in ignored; a new start then replays from idx 0.
//  6 second start pulse mid-readout with different nclust -> ignored;
//    beat count equals the first nclust.

Source files
------------

// File: rtl/jet_readout_l1.sv
// Jet-merger memory reader: walks addresses 0..N-1 under a credit limit, absorbs the
// fixed RAM latency and streams jets downstream through a small show-ahead FIFO.
module jet_readout_l1 #(
    parameter int JET_W  = 23,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 2,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] nclust,
    output logic [ADDR_W-1:0] jet_addr,
    input  logic [JET_W-1:0]  jet_in,
    output logic [JET_W-1:0]  out_jet,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    // The output register is the FIFO head; the array holds the remaining FIFO_D-1 entries.
    localparam int MEM_D = FIFO_D - 1;
    localparam int PTR_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;
    localparam int CNT_W = $clog2(FIFO_D + RD_LAT + 1);
    localparam logic [CNT_W-1:0] FIFO_CAP = CNT_W'(FIFO_D);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_D - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] n_reg, addr_reg, n_last;
    logic [RD_LAT-1:0] pipe_vld_reg;
    logic [ADDR_W-1:0] pipe_idx_reg [RD_LAT];
    logic [JET_W-1:0]  mem_jet [MEM_D];
    logic [ADDR_W-1:0] mem_idx [MEM_D];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  mem_cnt_reg, inflight, total, occupancy;
    logic [JET_W-1:0]  out_jet_reg;
    logic [ADDR_W-1:0] out_idx_reg, push_idx;
    logic              out_valid_reg, out_last_reg;
    logic              issue, push, pop, load_out, mem_push, mem_pop;

    assign n_last   = n_reg - ADDR_W'(1);
    assign push     = pipe_vld_reg[RD_LAT-1];
    assign push_idx = pipe_idx_reg[RD_LAT-1];
    assign pop      = out_valid_reg && out_ready;
    assign load_out = !out_valid_reg || pop;
    assign mem_pop  = load_out && (mem_cnt_reg != '0);
    // A push bypasses the array only when the head register is free and nothing is queued.
    assign mem_push = push && !(load_out && (mem_cnt_reg == '0));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_vld_reg[i]);
        end
    end

    assign total     = mem_cnt_reg + CNT_W'(out_valid_reg);
    assign occupancy = total + inflight;
    assign issue     = (state_reg == READ) && (occupancy < FIFO_CAP);
    assign jet_addr  = issue ? addr_reg : '1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (nclust != '0) ? READ : DONE;
            READ:    if (issue && (addr_reg == n_last)) state_next = DRAIN;
            DRAIN:   if ((inflight == '0) &&
                         ((total == '0) || ((total == CNT_ONE) && pop))) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && start) begin
                n_reg    <= nclust;
                addr_reg <= '0;
            end else if (issue && (addr_reg != n_last)) begin
                addr_reg <= addr_reg + ADDR_W'(1);
            end
        end
    end

    // Issue tracker: one valid bit plus index per cycle of read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld_reg <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_idx_reg[i] <= '0;
        end else begin
            pipe_vld_reg[0] <= issue;
            pipe_idx_reg[0] <= addr_reg;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_reg[i] <= pipe_vld_reg[i-1];
                pipe_idx_reg[i] <= pipe_idx_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_push) begin
            mem_jet[wr_ptr_reg] <= jet_in;
            mem_idx[wr_ptr_reg] <= push_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_jet_reg   <= '0;
            out_idx_reg   <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            if (mem_push) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
            if (mem_pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
            case ({mem_push, mem_pop})
                2'b10:   mem_cnt_reg <= mem_cnt_reg + CNT_ONE;
                2'b01:   mem_cnt_reg <= mem_cnt_reg - CNT_ONE;
                default: mem_cnt_reg <= mem_cnt_reg;
            endcase
            if (load_out) begin
                if (mem_cnt_reg != '0) begin
                    out_valid_reg <= 1'b1;
                    out_jet_reg   <= mem_jet[rd_ptr_reg];
                    out_idx_reg   <= mem_idx[rd_ptr_reg];
                    out_last_reg  <= (mem_idx[rd_ptr_reg] == n_last);
                end else if (push) begin
                    out_valid_reg <= 1'b1;
                    out_jet_reg   <= jet_in;
                    out_idx_reg   <= push_idx;
                    out_last_reg  <= (push_idx == n_last);
                end else begin
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            end
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && (total == FIFO_CAP)));

    assign out_jet   = out_jet_reg;
    assign out_idx   = out_idx_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
endmodule
